echo_engine: RTL and testbench

//  Parametrised echo processor for the ADC->DAC audio path. Offset-binary in, offset-binary out.

---
 rtl/echo_pkg.sv | 18 +
 rtl/echo_delay_ram.sv | 28 ++
 rtl/echo_engine.sv | 122 ++++++++++++
 tb/tb_echo_engine.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared types and constants for the echo engine: FSM state, mode encodings and the
// offset-binary bias helper.
package echo_pkg;

    typedef enum logic [0:0] {
        StFill = 1'b0,
        StRun  = 1'b1
    } echo_state_e;

    localparam logic MODE_FF = 1'b0;
    localparam logic MODE_FB = 1'b1;

    // Bias between offset-binary samples and the internal 2's-complement form.
    function automatic int unsigned echo_offset(input int unsigned data_w);
        return 32'd1 << (data_w - 32'd1);
    endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Echo delay line storage: one write port and a registered read port, shaped to map onto
// block RAM. Contents are not reset.
module echo_delay_ram #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 8192,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/echo_engine.sv
// Echo processor between ADC capture and DAC output: circular delay buffer, feedforward or
// feedback echo, shift gain. Define ECHO_SAT_EN to saturate the mix instead of wrapping.
module echo_engine
    import echo_pkg::*;
#(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned DEPTH      = 8192,
    parameter int unsigned GAIN_SHIFT = 1,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic [ADDR_W:0]   delay_len,
    input  logic              mode,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid
);

    localparam int unsigned       LenW   = ADDR_W + 1;
    localparam logic [DATA_W-1:0] Offset = DATA_W'(echo_offset(DATA_W));
    localparam logic [LenW-1:0]   DepthL = LenW'(DEPTH);

    echo_state_e       state_q, state_d;
    logic [LenW-1:0]   fill_q, fill_d;
    logic [LenW-1:0]   dl_q;
    logic [LenW-1:0]   del_eff;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_addr;
    logic              dv_q, dv_qq, stb;
    logic              dl_chg, run_eff;
    logic [DATA_W-1:0] q_raw, wr_data;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_valid_q;

    logic signed [DATA_W-1:0] x, q, q_sh, y;

    assign stb     = dv_q & ~dv_qq;
    assign del_eff = (delay_len > DepthL) ? DepthL : delay_len;
    assign dl_chg  = (del_eff != dl_q);
    // A length change reopens the fill window, so ignore stale buffer data at once.
    assign run_eff = (state_q == StRun) && !dl_chg;
    assign rd_addr = wr_ptr_q - del_eff[ADDR_W-1:0];

    assign x    = data_in - Offset;
    assign q    = run_eff ? q_raw : '0;
    assign q_sh = q >>> GAIN_SHIFT;

`ifdef ECHO_SAT_EN
    logic signed [DATA_W:0] y_full;
    assign y_full = {x[DATA_W-1], x} - {q_sh[DATA_W-1], q_sh};
    always_comb begin
        y = y_full[DATA_W-1:0];
        if (y_full[DATA_W] != y_full[DATA_W-1]) begin
            y = y_full[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign y = x - q_sh;
`endif

    assign wr_data    = (mode == MODE_FB) ? y : x;
    assign data_out_d = stb ? (y + Offset) : data_out_q;

    echo_delay_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (sysclk),
        .we_i    (stb),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (q_raw)
    );

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (dl_chg) begin
            state_d = StFill;
            fill_d  = '0;
        end else if (stb && state_q == StFill && del_eff != '0) begin
            if (fill_q + LenW'(1) == del_eff) begin
                state_d = StRun;
                fill_d  = del_eff;
            end else begin
                fill_d = fill_q + LenW'(1);
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            fill_q      <= '0;
            dl_q        <= '0;
            wr_ptr_q    <= '0;
            dv_q        <= 1'b0;
            dv_qq       <= 1'b0;
            data_out_q  <= Offset;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            dl_q        <= del_eff;
            dv_q        <= data_valid;
            dv_qq       <= dv_q;
            data_out_q  <= data_out_d;
            out_valid_q <= stb;
            if (stb) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_echo_engine.sv
// Scoreboard bench for echo_engine (DATA_W=10, DEPTH=16, GAIN_SHIFT=1): directed samples push
// hand-computed outputs; a negedge monitor pops and compares on every out_valid.
module tb_echo_engine;

    localparam int DW = 10;
    localparam int AW = 4;
`ifdef ECHO_SAT_EN
    localparam int SatExp = 1023;
`else
    localparam int SatExp = 255;
`endif

    logic          sysclk     = 1'b0;
    logic          rst_n      = 1'b0;
    logic [DW-1:0] data_in    = '0;
    logic          data_valid = 1'b0;
    logic [AW:0]   delay_len  = 5'd4;
    logic          mode       = 1'b0;
    logic [DW-1:0] data_out;
    logic          out_valid;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int exp_q[$];

    int t2_exp[9]  = '{612, 512, 512, 512, 462, 512, 512, 512, 512};
    int t3_exp[17] = '{612, 512, 512, 512, 462, 512, 512, 512, 537,
                       512, 512, 512, 500, 512, 512, 512, 518};

    always #5 sysclk = ~sysclk;

    echo_engine #(
        .DATA_W     (10),
        .DEPTH      (16),
        .GAIN_SHIFT (1)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .delay_len  (delay_len),
        .mode       (mode),
        .data_out   (data_out),
        .out_valid  (out_valid)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge sysclk) begin
        int e;
        if (rst_n && out_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("data_out", int'(data_out), e);
            end
        end
    end

    // Entered and left at #1 after a rising edge.
    task automatic send(input int din, input int exp);
        exp_q.push_back(exp);
        data_in    = DW'(din);
        data_valid = 1'b1;
        repeat (2) @(posedge sysclk);
        #1 data_valid = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset(input string name);
        @(posedge sysclk);
        #1 rst_n = 1'b0;
        #1;
        check({name, " data_out in reset"}, int'(data_out), 512);
        check({name, " out_valid in reset"}, int'(out_valid), 0);
        @(posedge sysclk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
    endtask

    initial begin
        int p0;
        // 1: reset state, long data_valid level gives a single pulse
        do_reset("t1");
        p0 = pulses;
        exp_q.push_back(512);
        data_in    = 10'd512;
        data_valid = 1'b1;
        repeat (20) @(posedge sysclk);
        #1 data_valid = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        check("t1 pulses for held level", pulses - p0, 1);

        // 2: feedforward single echo
        do_reset("t2");
        mode = 1'b0;
        for (int i = 0; i < 9; i++) send(i == 0 ? 612 : 512, t2_exp[i]);

        // 3: feedback decaying echoes, including buffer wrap
        do_reset("t3");
        mode = 1'b1;
        for (int i = 0; i < 17; i++) send(i == 0 ? 612 : 512, t3_exp[i]);

        // 4: overflow at the mix, saturate or wrap
        do_reset("t4");
        mode = 1'b0;
        send(0, 0);
        for (int i = 0; i < 3; i++) send(512, 512);
        send(1023, SatExp);

        // 5: shorten delay in RUN, then bypass
        do_reset("t5");
        for (int i = 0; i < 5; i++) send(512, 512);
        delay_len = 5'd2;
        send(612, 612);
        send(512, 512);
        send(512, 462);
        send(512, 512);
        delay_len = 5'd0;
        send(612, 612);
        send(512, 512);
        send(512, 512);
        send(512, 512);
        delay_len = 5'd4;

        // 6: reset mid-stream restarts the fill
        do_reset("t6");
        send(612, 612);
        send(512, 512);
        do_reset("t6 mid");
        for (int i = 0; i < 4; i++) send(612, 612);
        send(512, 462);

        repeat (5) @(posedge sysclk);
        #1;
        check("outstanding expected outputs", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
